// File: rtl/gs_pkg.sv
// Shared types and constants for the Goldschmidt divide/square-root core.
package gs_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'd0,
    OpSqrt = 2'd1,
    OpRsv2 = 2'd2,
    OpRsv3 = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    RmRne = 2'd0,
    RmRz  = 2'd1,
    RmRdn = 2'd2,
    RmRup = 2'd3
  } rmode_e;

  localparam logic [1:0] RNE = 2'd0;
  localparam logic [1:0] RZ  = 2'd1;
  localparam logic [1:0] RDN = 2'd2;
  localparam logic [1:0] RUP = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StIterK,
    StIterN,
    StIterD,
    StRem,
    StRound,
    StDone
  } state_e;

  // Accept-to-out_valid latency in cycles for a given operation and iteration count.
  function automatic int unsigned latency(input logic is_sqrt, input int unsigned iter);
    return is_sqrt ? (3 * iter + 3) : (2 * iter + 3);
  endfunction

endpackage

// File: rtl/gs_seed_rom.sv
// Seed table: reciprocal and reciprocal-square-root starting points for Goldschmidt.
// Output is K0 in 0.SEED_W fixed point, evaluated at the midpoint of each index interval.
module gs_seed_rom #(
  parameter int unsigned SEED_W = 8
) (
  input  logic [SEED_W-2:0] i_idx,
  input  logic              i_sqrt,
  input  logic              i_odd,
  output logic [SEED_W-1:0] o_seed
);

  localparam int unsigned Entries = 2 ** (SEED_W - 1);

  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned r, t;
    r = 64'd0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic logic [SEED_W-1:0] rcp_entry(input int unsigned idx);
    longint unsigned m, v, lim;
    m   = (64'd1 << SEED_W) + 64'(2 * idx + 1);
    v   = ((64'd1 << (2 * SEED_W + 1)) + m) / (64'd2 * m);
    lim = (64'd1 << SEED_W) - 64'd1;
    if (v > lim) v = lim;
    return SEED_W'(v);
  endfunction

  // Radicand midpoint is m/2^SEED_W, doubled for odd exponents.
  function automatic logic [SEED_W-1:0] rsq_entry(input int unsigned idx, input int unsigned odd);
    longint unsigned m, x, v, lim;
    m   = (64'd1 << SEED_W) + 64'(2 * idx + 1);
    x   = (64'd1 << (3 * SEED_W + 2)) / (m << odd);
    v   = (isqrt(x) + 64'd1) >> 1;
    lim = (64'd1 << SEED_W) - 64'd1;
    if (v > lim) v = lim;
    return SEED_W'(v);
  endfunction

  logic [SEED_W-1:0] w_rcp  [Entries];
  logic [SEED_W-1:0] w_rsq0 [Entries];
  logic [SEED_W-1:0] w_rsq1 [Entries];

  for (genvar gi = 0; gi < Entries; gi++) begin : g_tab
    assign w_rcp[gi]  = rcp_entry(gi);
    assign w_rsq0[gi] = rsq_entry(gi, 0);
    assign w_rsq1[gi] = rsq_entry(gi, 1);
  end

  // Select table by operation and exponent parity.
  always_comb begin
    o_seed = w_rcp[i_idx];
    if (i_sqrt) o_seed = i_odd ? w_rsq1[i_idx] : w_rsq0[i_idx];
  end

endmodule

// File: rtl/gs_divsqrt_core.sv
// Goldschmidt significand divide / square-root with exact remainder correction and rounding.
// Internal fixed point: GW bits, two integer bits, F = GW-2 fraction bits.
module gs_divsqrt_core
  import gs_pkg::*;
#(
  parameter int unsigned MW     = 24,
  parameter int unsigned ITER   = 3,
  parameter int unsigned SEED_W = 8,
  parameter int unsigned GW     = MW + 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [1:0]    i_op,
  input  logic [1:0]    i_rmode,
  input  logic          i_sign,
  input  logic [MW-1:0] i_a_mant,
  input  logic [MW-1:0] i_b_mant,
  input  logic          i_a_odd,
  input  logic          i_abort,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [MW-1:0] o_q_mant,
  output logic          o_q_lt1,
  output logic          o_q_carry,
  output logic          o_inexact
);

  localparam int unsigned F      = GW - 2;
  localparam int unsigned AShift = F - (MW - 1);
  localparam int unsigned QShift = F - MW;
  localparam int unsigned RW     = 2 * MW + 4;
  localparam int unsigned IW     = $clog2(ITER + 1);
  localparam logic [2*GW-1:0] MulHalf = (2 * GW)'(1) << (F - 1);
  localparam logic [GW-1:0]   FxTwo   = GW'(2) << F;
  localparam logic [GW-1:0]   FxThree = GW'(3) << F;

  state_e r_state, w_state_nxt;

  logic          r_sqrt, r_sign, r_odd, r_lt1, r_sticky;
  logic [1:0]    r_rmode;
  logic [MW-1:0] r_a, r_b;
  logic [GW-1:0] r_n, r_d, r_k, r_k2;
  logic [IW-1:0] r_iter;
  logic [MW:0]   r_q;
  logic [MW-1:0] r_q_mant;
  logic          r_q_lt1, r_q_carry, r_inexact;

  logic [SEED_W-2:0] w_seed_idx;
  logic [SEED_W-1:0] w_seed;
  logic [GW-1:0]     w_ma, w_mb, w_mul, w_k_next, w_a_fx;
  logic [2*GW-1:0]   w_prod;
  logic              w_last;
  logic [MW:0]       w_q_hi, w_q_lo, w_q, w_q_fix;
  logic [RW-1:0]     w_lhs, w_sub, w_fix, w_rem, w_rem_fix;
  logic              w_neg, w_sticky, w_inc, w_carry;
  logic [MW:0]       w_sum;
  logic [MW-1:0]     w_round;

  assign w_seed_idx = r_sqrt ? r_a[MW-2 -: SEED_W-1] : r_b[MW-2 -: SEED_W-1];

  gs_seed_rom #(
    .SEED_W(SEED_W)
  ) u_seed_rom (
    .i_idx (w_seed_idx),
    .i_sqrt(r_sqrt),
    .i_odd (r_odd),
    .o_seed(w_seed)
  );

  assign w_a_fx = r_odd ? (GW'(r_a) << (AShift + 1)) : (GW'(r_a) << AShift);

  // Shared multiplier operand selection, one product per cycle.
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    case (r_state)
      StIterK: begin w_ma = r_k; w_mb = r_k; end
      StIterN: begin w_ma = r_n; w_mb = r_k; end
      StIterD: begin w_ma = r_d; w_mb = r_sqrt ? r_k2 : r_k; end
      default: ;
    endcase
  end

  // Products are rounded to nearest so truncation drift stays symmetric.
  assign w_prod   = {{GW{1'b0}}, w_ma} * {{GW{1'b0}}, w_mb};
  assign w_mul    = GW'((w_prod + MulHalf) >> F);
  assign w_k_next = r_sqrt ? ((FxThree - w_mul) >> 1) : (FxTwo - w_mul);
  assign w_last   = (r_iter == IW'(ITER - 1));

  // Half-ulp bias makes q either exact or one ulp high; the remainder step fixes the latter.
  assign w_q_hi = (MW + 1)'((r_n + (GW'(1) << (QShift - 1))) >> QShift);
  assign w_q_lo = (MW + 1)'((r_n + (GW'(1) << (QShift - 2))) >> (QShift - 1));
  assign w_q    = r_lt1 ? w_q_lo : w_q_hi;

  // Exact remainder and one-ulp downward correction.
  always_comb begin
    if (r_sqrt) begin
      w_lhs = r_odd ? (RW'(r_a) << (MW + 2)) : (RW'(r_a) << (MW + 1));
      w_sub = RW'(w_q) * RW'(w_q);
      w_fix = (RW'(w_q) << 1) - RW'(1);
    end else begin
      w_lhs = r_lt1 ? (RW'(r_a) << (MW + 1)) : (RW'(r_a) << MW);
      w_sub = RW'(w_q) * RW'(r_b);
      w_fix = RW'(r_b);
    end
    w_rem     = w_lhs - w_sub;
    w_rem_fix = w_rem + w_fix;
    w_neg     = w_rem[RW-1];
    w_q_fix   = w_neg ? (w_q - (MW + 1)'(1)) : w_q;
    w_sticky  = w_neg ? (w_rem_fix != '0) : (w_rem != '0);
  end

  // Rounding increment from guard bit, sticky and mode.
  always_comb begin
    w_inc = 1'b0;
    case (r_rmode)
      RNE:     w_inc = r_q[0] & (r_sticky | r_q[1]);
      RZ:      w_inc = 1'b0;
      RDN:     w_inc = r_sign & (r_q[0] | r_sticky);
      default: w_inc = ~r_sign & (r_q[0] | r_sticky);
    endcase
    w_sum   = {1'b0, r_q[MW:1]} + (MW + 1)'(w_inc);
    w_carry = w_sum[MW];
    w_round = w_carry ? (MW'(1) << (MW - 1)) : w_sum[MW-1:0];
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic; abort wins in every busy state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (i_in_valid) w_state_nxt = StSeed;
      StSeed:  w_state_nxt = r_sqrt ? StIterK : StIterN;
      StIterK: w_state_nxt = StIterN;
      StIterN: w_state_nxt = StIterD;
      StIterD: w_state_nxt = w_last ? StRem : (r_sqrt ? StIterK : StIterN);
      StRem:   w_state_nxt = StRound;
      StRound: w_state_nxt = StDone;
      StDone:  if (i_out_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (i_abort && r_state != StIdle) w_state_nxt = StIdle;
  end

  // FSM outputs.
  always_comb begin
    o_in_ready  = (r_state == StIdle);
    o_out_valid = (r_state == StDone);
  end

  // Datapath registers, loaded according to the current state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sqrt <= 1'b0;  r_sign <= 1'b0;  r_odd <= 1'b0;  r_lt1 <= 1'b0;
      r_rmode <= '0;   r_a <= '0;       r_b <= '0;
      r_n <= '0;       r_d <= '0;       r_k <= '0;      r_k2 <= '0;
      r_iter <= '0;    r_q <= '0;       r_sticky <= 1'b0;
      r_q_mant <= '0;  r_q_lt1 <= 1'b0; r_q_carry <= 1'b0; r_inexact <= 1'b0;
    end else begin
      case (r_state)
        StIdle: if (i_in_valid) begin
          r_sqrt  <= (i_op == OpSqrt);
          r_rmode <= i_rmode;
          r_sign  <= i_sign;
          r_a     <= i_a_mant;
          r_b     <= i_b_mant;
          r_odd   <= (i_op == OpSqrt) & i_a_odd;
          r_lt1   <= (i_op != OpSqrt) & (i_a_mant < i_b_mant);
          r_iter  <= '0;
        end
        StSeed: begin
          r_n <= w_a_fx;
          r_d <= r_sqrt ? w_a_fx : (GW'(r_b) << AShift);
          r_k <= GW'(w_seed) << (F - SEED_W);
        end
        StIterK: r_k2 <= w_mul;
        StIterN: r_n  <= w_mul;
        StIterD: begin
          r_d    <= w_mul;
          r_k    <= w_k_next;
          r_iter <= r_iter + IW'(1);
        end
        StRem: begin
          r_q      <= w_q_fix;
          r_sticky <= w_sticky;
        end
        StRound: begin
          r_q_mant  <= w_round;
          r_q_lt1   <= r_lt1;
          r_q_carry <= w_carry;
          // Inexact covers both the guard bit and the remainder beyond it.
          r_inexact <= r_q[0] | r_sticky;
        end
        default: ;
      endcase
    end
  end

  assign o_q_mant  = r_q_mant;
  assign o_q_lt1   = r_q_lt1;
  assign o_q_carry = r_q_carry;
  assign o_inexact = r_inexact;

endmodule
